// File: rtl/mole_if.sv
// Game-side bundle for the mole controller: enable/difficulty/buttons in, LEDs and score pulses out.
interface mole_if #(
  parameter int NUM_MOLES = 4
) ();
  logic                 enable;
  logic [1:0]           difficulty_level;
  logic [NUM_MOLES-1:0] hit_btn;
  logic [NUM_MOLES-1:0] mole_leds;
  logic                 hit_pulse;
  logic                 miss_pulse;
  logic                 wrong_pulse;

  modport master (
    output enable, difficulty_level, hit_btn,
    input  mole_leds, hit_pulse, miss_pulse, wrong_pulse
  );

  modport slave (
    input  enable, difficulty_level, hit_btn,
    output mole_leds, hit_pulse, miss_pulse, wrong_pulse
  );
endinterface

// File: rtl/mole_controller.sv
// Whack-a-mole generator and hit judge: LFSR-placed moles, ms-timed gap/window, registered score pulses.
// Optional post-hit all-LED flash is compiled in with `define MOLE_FEEDBACK_EN.
module mole_controller #(
  parameter int NUM_MOLES     = 4,
  parameter int CYCLES_PER_MS = 100000,
  parameter int GAP_MS        = 300,
  parameter int FB_MS         = 200
) (
  input logic   clk,
  input logic   rst,
  mole_if.slave bus
);

  localparam int LW     = $clog2(NUM_MOLES);
  localparam int PW     = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam int MAX_A  = (GAP_MS > 1500) ? GAP_MS : 1500;
  localparam int MAX_MS = (FB_MS > MAX_A) ? FB_MS : MAX_A;
  localparam int MW     = $clog2(MAX_MS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
`ifdef MOLE_FEEDBACK_EN
    S_FB,
`endif
    S_UP
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        psc_q, psc_d;
  logic [MW-1:0]        ms_q, ms_d;
  logic [MW-1:0]        win_q, win_d;
  logic [LW-1:0]        pos_q, pos_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] leds_q, leds_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 wrong_q, wrong_d;

  logic                 tick;
  logic                 expire;
  logic [MW-1:0]        dur_ms;
  logic [LW-1:0]        cand;
  logic [LW-1:0]        pick;

  function automatic logic [MW-1:0] window_ms(input logic [1:0] level);
    case (level)
      2'b00:   window_ms = MW'(1500);
      2'b01:   window_ms = MW'(1000);
      2'b10:   window_ms = MW'(700);
      default: window_ms = MW'(500);
    endcase
  endfunction

  // Current state's length in ms; a state of D ms expires on the last prescaler step of ms D-1.
  always_comb begin
    case (state_q)
      S_GAP:   dur_ms = MW'(GAP_MS);
      S_UP:    dur_ms = win_q;
`ifdef MOLE_FEEDBACK_EN
      S_FB:    dur_ms = MW'(FB_MS);
`endif
      default: dur_ms = MW'(1);
    endcase
  end

  assign tick   = (psc_q == PW'(CYCLES_PER_MS - 1));
  assign expire = tick && (ms_q == dur_ms - MW'(1));
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign cand   = lfsr_q[LW-1:0];
  // NUM_MOLES is a power of two, so the +1 wraps modulo NUM_MOLES by width alone.
  assign pick   = (cand == pos_q) ? cand + LW'(1) : cand;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pos_d   = pos_q;
    leds_d  = leds_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    wrong_d = 1'b0;

    if (!bus.enable) begin
      state_d = S_IDLE;
      leds_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_GAP;
          leds_d  = '0;
        end
        S_GAP: begin
          if (expire) begin
            state_d = S_UP;
            win_d   = window_ms(bus.difficulty_level);
            pos_d   = pick;
            leds_d  = NUM_MOLES'(1) << pick;
          end
        end
        S_UP: begin
          if (bus.hit_btn[pos_q]) begin
            hit_d = 1'b1;
`ifdef MOLE_FEEDBACK_EN
            state_d = S_FB;
            leds_d  = '1;
`else
            state_d = S_GAP;
            leds_d  = '0;
`endif
          end else if (expire) begin
            miss_d  = 1'b1;
            state_d = S_GAP;
            leds_d  = '0;
          end else if (|bus.hit_btn) begin
            wrong_d = 1'b1;
          end
        end
`ifdef MOLE_FEEDBACK_EN
        S_FB: begin
          if (expire) begin
            state_d = S_GAP;
            leds_d  = '0;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          leds_d  = '0;
        end
      endcase
    end

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      psc_d = '0;
      ms_d  = '0;
    end else if (tick) begin
      psc_d = '0;
      ms_d  = ms_q + MW'(1);
    end else begin
      psc_d = psc_q + PW'(1);
      ms_d  = ms_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      ms_q    <= '0;
      win_q   <= '0;
      pos_q   <= '0;
      lfsr_q  <= 16'hACE1;
      leds_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      ms_q    <= ms_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      lfsr_q  <= lfsr_d;
      leds_q  <= leds_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wrong_q <= wrong_d;
    end
  end

  assign bus.mole_leds   = leds_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.wrong_pulse = wrong_q;

endmodule

// File: tb/tb_mole_controller.sv
// Scenario bench for mole_controller: pulse scoreboard plus LED timing and placement checks.
module tb_mole_controller;

  localparam int NM      = 4;
  localparam int CPM     = 2;
  localparam int GAP     = 3;
  localparam int FB      = 2;
  localparam int GAP_CYC = GAP * CPM;
  localparam int FB_CYC  = FB * CPM;

  localparam logic [2:0] P_HIT   = 3'b100;
  localparam logic [2:0] P_MISS  = 3'b010;
  localparam logic [2:0] P_WRONG = 3'b001;

`ifdef MOLE_FEEDBACK_EN
  localparam logic [NM-1:0] AFTER_HIT = '1;
`else
  localparam logic [NM-1:0] AFTER_HIT = '0;
`endif

  logic clk = 1'b0;
  logic rst;

  mole_if #(.NUM_MOLES(NM)) bus ();

  mole_controller #(
    .NUM_MOLES    (NM),
    .CYCLES_PER_MS(CPM),
    .GAP_MS       (GAP),
    .FB_MS        (FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  function automatic int window_cycles(input logic [1:0] level);
    case (level)
      2'b00:   window_cycles = 1500 * CPM;
      2'b01:   window_cycles = 1000 * CPM;
      2'b10:   window_cycles = 700 * CPM;
      default: window_cycles = 500 * CPM;
    endcase
  endfunction

  // Pulse scoreboard: every observed pulse must match the oldest expected one.
  always @(negedge clk) begin
    logic [2:0] obs;
    logic [2:0] exp_p;
    obs = {bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse};
    if (obs != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got hit/miss/wrong=%b, none expected at %0t", obs, $time);
      end else begin
        exp_p = exp_q.pop_front();
        if (obs !== exp_p) begin
          errors++;
          $display("FAIL pulse_kind: got hit/miss/wrong=%b, expected %b at %0t", obs, exp_p, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic measure(input bit want_lit, input int limit, output int n);
    n = 0;
    while (((bus.mole_leds != '0) == want_lit) && (n < limit)) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic next_mole();
    int n;
    measure(1'b1, 5000, n);
    measure(1'b0, 5000, n);
    checks++;
    if ($countones(bus.mole_leds) != 1) begin
      errors++;
      $display("FAIL next_mole_onehot: leds=%b, required one-hot", bus.mole_leds);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.difficulty_level = 2'b00;
    bus.hit_btn = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mole_leds !== '0) begin
      errors++;
      $display("FAIL reset_leds: leds=%b, required 0", bus.mole_leds);
    end
    checks++;
    if ({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: pulses=%b, required 000",
               {bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.mole_leds !== '0) begin
      errors++;
      $display("FAIL idle_disabled_leds: leds=%b, required 0", bus.mole_leds);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [NM-1:0] prev;
    bus.difficulty_level = 2'b11;
    bus.enable = 1'b1;
    @(negedge clk);
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL first_gap_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    checks++;
    if ($countones(bus.mole_leds) != 1) begin
      errors++;
      $display("FAIL first_mole_onehot: leds=%b, required one-hot", bus.mole_leds);
    end
    prev = bus.mole_leds;
    exp_q.push_back(P_MISS);
    measure(1'b1, 5000, n);
    checks++;
    if (n != window_cycles(2'b11)) begin
      errors++;
      $display("FAIL window_d3_len: lit cycles=%0d, required %0d", n, window_cycles(2'b11));
    end
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL gap_after_miss_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    checks++;
    if (($countones(bus.mole_leds) != 1) || (bus.mole_leds == prev)) begin
      errors++;
      $display("FAIL second_mole_pos: leds=%b, required one-hot and not %b", bus.mole_leds, prev);
    end
    check_drained("timeout_miss_seen");
  endtask

  task automatic test_hit();
    int n;
    logic [NM-1:0] lit;
    lit = bus.mole_leds;
    repeat (9) @(negedge clk);
    bus.hit_btn = lit;
    exp_q.push_back(P_HIT);
    @(negedge clk);
    bus.hit_btn = '0;
    checks++;
    if (bus.mole_leds !== AFTER_HIT) begin
      errors++;
      $display("FAIL hit_leds: leds=%b, required %b", bus.mole_leds, AFTER_HIT);
    end
`ifdef MOLE_FEEDBACK_EN
    measure(1'b1, 100, n);
    checks++;
    if (n != FB_CYC) begin
      errors++;
      $display("FAIL feedback_len: lit cycles=%0d, required %0d", n, FB_CYC);
    end
`endif
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL gap_after_hit_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    check_drained("hit_seen");
  endtask

  task automatic test_wrong();
    int n;
    logic [NM-1:0] lit, other;
    lit = bus.mole_leds;
    other = {lit[NM-2:0], lit[NM-1]};
    repeat (4) @(negedge clk);
    bus.hit_btn = other;
    exp_q.push_back(P_WRONG);
    @(negedge clk);
    bus.hit_btn = '0;
    exp_q.push_back(P_MISS);
    checks++;
    if (bus.mole_leds !== lit) begin
      errors++;
      $display("FAIL wrong_led_held: leds=%b, required %b", bus.mole_leds, lit);
    end
    measure(1'b1, 5000, n);
    checks++;
    if (n + 5 != window_cycles(2'b11)) begin
      errors++;
      $display("FAIL wrong_window_len: lit cycles=%0d, required %0d", n + 5, window_cycles(2'b11));
    end
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL wrong_gap_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    check_drained("wrong_then_miss_seen");
  endtask

  task automatic test_hit_with_wrong();
    logic [NM-1:0] lit, other;
    lit = bus.mole_leds;
    other = {lit[NM-2:0], lit[NM-1]};
    repeat (2) @(negedge clk);
    bus.hit_btn = lit | other;
    exp_q.push_back(P_HIT);
    @(negedge clk);
    bus.hit_btn = '0;
    checks++;
    if (bus.mole_leds !== AFTER_HIT) begin
      errors++;
      $display("FAIL combo_hit_leds: leds=%b, required %b", bus.mole_leds, AFTER_HIT);
    end
    next_mole();
    check_drained("combo_hit_only");
  endtask

  task automatic test_last_cycle();
    logic [NM-1:0] lit;
    lit = bus.mole_leds;
    repeat (window_cycles(2'b11) - 1) @(negedge clk);
    checks++;
    if (bus.mole_leds !== lit) begin
      errors++;
      $display("FAIL last_cycle_lit: leds=%b, required %b", bus.mole_leds, lit);
    end
    bus.hit_btn = lit;
    exp_q.push_back(P_HIT);
    @(negedge clk);
    bus.hit_btn = '0;
    checks++;
    if (bus.mole_leds !== AFTER_HIT) begin
      errors++;
      $display("FAIL last_cycle_hit_leds: leds=%b, required %b", bus.mole_leds, AFTER_HIT);
    end
    next_mole();
    check_drained("last_cycle_hit_no_miss");
  endtask

  task automatic test_enable_drop();
    int n;
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mole_leds !== '0) begin
      errors++;
      $display("FAIL drop_leds: leds=%b, required 0", bus.mole_leds);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.mole_leds !== '0) begin
      errors++;
      $display("FAIL disabled_dark: leds=%b, required 0", bus.mole_leds);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL reenable_gap_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    check_drained("drop_no_pulses");
  endtask

  task automatic test_difficulty();
    int n;
    int cur;
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b10, 2'b11};
    cur = window_cycles(2'b11);
    for (int i = 0; i < 4; i++) begin
      bus.difficulty_level = seq[i];
      exp_q.push_back(P_MISS);
      measure(1'b1, 5000, n);
      checks++;
      if (n != cur) begin
        errors++;
        $display("FAIL difficulty_window[%0d]: lit cycles=%0d, required %0d", i, n, cur);
      end
      measure(1'b0, 100, n);
      checks++;
      if (n != GAP_CYC) begin
        errors++;
        $display("FAIL difficulty_gap[%0d]: dark cycles=%0d, required %0d", i, n, GAP_CYC);
      end
      cur = window_cycles(seq[i]);
    end
    check_drained("difficulty_misses");
  endtask

  task automatic test_back_to_back();
    logic [NM-1:0] prev, cur, seen;
    prev = bus.mole_leds;
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      cur = bus.mole_leds;
      checks++;
      if ($countones(cur) != 1) begin
        errors++;
        $display("FAIL b2b_onehot[%0d]: leds=%b, required one-hot", i, cur);
      end
      if (i > 0) begin
        checks++;
        if (cur == prev) begin
          errors++;
          $display("FAIL b2b_repeat[%0d]: leds=%b, required different from %b", i, cur, prev);
        end
      end
      seen |= cur;
      prev = cur;
      bus.hit_btn = cur;
      exp_q.push_back(P_HIT);
      @(negedge clk);
      bus.hit_btn = '1;
      @(negedge clk);
      bus.hit_btn = '0;
      next_mole();
    end
    checks++;
    if (seen !== '1) begin
      errors++;
      $display("FAIL all_positions_seen: seen=%b, required %b", seen, {NM{1'b1}});
    end
    check_drained("b2b_hits");
  endtask

  task automatic test_reset_mid_mole();
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mole_leds, bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: leds=%b pulses=%b, required all 0", bus.mole_leds,
               {bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse});
    end
    rst = 1'b0;
    @(negedge clk);
    measure(1'b0, 100, n);
    checks++;
    if (n != GAP_CYC) begin
      errors++;
      $display("FAIL post_reset_gap_len: dark cycles=%0d, required %0d", n, GAP_CYC);
    end
    check_drained("mid_reset_no_pulses");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_wrong();
    test_hit_with_wrong();
    test_last_cycle();
    test_enable_drop();
    test_difficulty();
    test_back_to_back();
    test_reset_mid_mole();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Mole generator and hit detector for the whack-a-mole game. It runs while the game FSM asserts its mole-control enable, raises one pseudo-random mole LED at a time, and holds it up for a difficulty-dependent window. Debounced button pulses are judged against the lit mole, producing one-cycle hit, miss and wrong pulses for the score counter downstream.

## Interface
- NUM_MOLES, 4: mole/LED/button count; legal values 2, 4, 8.
- CYCLES_PER_MS, 100000: clock cycles per millisecond.
- GAP_MS, 300: all-dark interval between moles, in ms.
- FB_MS, 200: hit-feedback flash length, in ms. Used only with MOLE_FEEDBACK_EN.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; high = game in PLAYING state.
- difficulty_level  in  2  00/01/10/11 → mole-up window 1500/1000/700/500 ms.
- hit_btn  in  NUM_MOLES  one-cycle button pulses, one bit per mole.
- mole_leds  out  NUM_MOLES  registered LED drive; at most one bit set, except during feedback.
- hit_pulse  out  1  one cycle per correct whack.
- miss_pulse  out  1  one cycle when a mole times out.
- wrong_pulse  out  1  one cycle per wrong-button event while a mole is up.

## Operation
- **States:**
  - IDLE: LEDs dark.
  - GAP: LEDs dark; presses ignored.
  - UP: one LED lit.
  - FEEDBACK: all LEDs lit; presses ignored. Exists only with the macro.
- **Enable:** enable low in any state → IDLE on the next cycle. LEDs clear and no pulse is emitted in that cycle. The LFSR is unaffected.
- IDLE → GAP when enable is high.
- **GAP → UP** after GAP_MS expires.
  - On entry: sample difficulty_level into the window register, pick the position, light that LED.
- **Position selection:**
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It advances every cycle outside reset.
  - Candidate = low log2(NUM_MOLES) bits.
  - If candidate equals the previous position, use (candidate+1) mod NUM_MOLES.
  - The previous-position register resets to 0.
- **UP:**
  - hit_btn bit at the lit position set → hit_pulse. Next state is FEEDBACK, or GAP without the macro.
  - Other bits set with the lit bit clear → wrong_pulse. Mole stays up and the window keeps running.
  - Correct bit plus other bits in the same cycle → hit only.
  - Window expiry with no hit → miss_pulse, → GAP.
  - Hit in the expiry cycle → hit wins; no miss.
- FEEDBACK → GAP after FB_MS.
- Difficulty changes mid-mole take effect at the next mole.

## Timing
- **Reset values:** mole_leds=0, all pulses=0, state IDLE, LFSR=16'hACE1, prescaler and ms counter =0.
- **Duration counting:**
  - Prescaler (0..CYCLES_PER_MS-1) produces ms ticks; an ms counter counts the ticks.
  - Both clear on every state entry.
  - A state of D ms lasts exactly D×CYCLES_PER_MS cycles, measured from its first cycle.
- **Latency:** all outputs are registered; an input in cycle N is reflected in cycle N+1.
  - enable rising at N → GAP from N+1.
  - Correct press at N → hit_pulse and LEDs cleared (or all-on with the macro) at N+1.
  - Expiry → miss_pulse coincides with the first GAP cycle.
- **Pulse rules:** pulses are one cycle wide and never overlap. A pulse in flight when enable drops is still emitted in its cycle.
- Reset mid-mole: next cycle matches reset values.
- Counter widths cover 1500×CYCLES_PER_MS without overflow.

## Configuration
- **MOLE_FEEDBACK_EN**
  - Defined: FEEDBACK state compiled in; after a hit all LEDs light for FB_MS, then GAP.
  - Undefined: the hit goes straight to GAP with LEDs dark, and FB_MS is unused.

## Test plan
Bench parameters: CYCLES_PER_MS=2, GAP_MS=3, FB_MS=2.
- Reset, enable=1, difficulty=11: LEDs dark 6 cycles, then one LED lit for exactly 1000 cycles. miss_pulse fires 1 cycle; LEDs dark 6 cycles.
- Press the lit bit 10 cycles into UP: hit_pulse next cycle, no miss. With macro, all LEDs lit for 4 cycles, then 6 dark cycles.
- Press a wrong bit during UP: wrong_pulse 1 cycle, LED stays, window length unchanged. Press wrong and correct together: hit_pulse only.
- Correct press in the final window cycle: hit_pulse, no miss_pulse.
- Drop enable mid-UP: LEDs 0 next cycle, no pulses. Re-enable: fresh 6-cycle GAP.
- 200 consecutive moles: no two consecutive positions equal; every position appears at least once; change difficulty mid-mole → new window applies only to the next mole.
